psdsqrt_sched: RTL and testbench
================================

PSDSQRT_SCHED -- requirements
Module: psdsqrt_sched

Interface
REQ-001 Parameter ITER, default 16: number of clock cycles the sqrt core needs between the cycle it samples start and the cycle it may sample stop.
REQ-002 clock  input  1  master clock; all logic is on the positive edge.
REQ-003 reset  input  1  master reset; synchronous and active-low.
REQ-004 req0  input  1  requester 0 operation request; held high until gnt0.
REQ-005 x0  input  32  requester 0 operand; valid while req0=1.
REQ-006 req1  input  1  requester 1 operation request; held high until gnt1.
REQ-007 x1  input  32  requester 1 operand; valid while req1=1.
REQ-008 gnt0  output  1  one-cycle pulse: x0 accepted.
REQ-009 gnt1  output  1  one-cycle pulse: x1 accepted.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  one-cycle pulse: result valid for requester done_id.
REQ-012 done_id  output  1  requester index of the completed operation.
REQ-013 result  output  16  floor(sqrt(operand)); held until the next done.
REQ-014 core_start  output  1  start pulse to the sqrt core.
REQ-015 core_stop  output  1  stop pulse to the sqrt core; loads the core output register.
REQ-016 core_xin  output  32  registered operand driven to the core.
REQ-017 core_sqrt  input  16  core result; valid from the cycle after core_stop.

Function
REQ-018 The FSM SHALL have the states IDLE, START, RUN, STOP and CAPTURE, and all outputs SHALL be registered.
REQ-019 IDLE -> START when req0|req1 is high at a posedge: latch the winner's operand into core_xin and its index into a tag register.
REQ-020 Arbitration SHALL be round-robin: a lone request wins; on a tie, the requester not granted last time wins; the pointer after reset favours req0.
REQ-021 START SHALL last 1 cycle with core_start=1 and the winner's gnt=1 (k+1 when the request was sampled at posedge k).
REQ-022 RUN SHALL last exactly ITER cycles, counted by a counter of width ceil(log2(ITER+1)), with core_start=0 and core_stop=0.
REQ-023 STOP SHALL last 1 cycle with core_stop=1.
REQ-024 CAPTURE SHALL last 1 cycle, loading result<=core_sqrt and done_id<=tag at its closing edge and setting done for the following cycle.
REQ-025 Timing SHALL be as follows:
  - The cycle after CAPTURE is IDLE with done=1.
  - Request-sample edge to done cycle is ITER+4 cycles (20 at the default).
  - In that IDLE cycle a pending request SHALL be sampled, giving back-to-back throughput of one operation per ITER+4 cycles.
REQ-026 core_xin SHALL remain stable from START through CAPTURE.
REQ-027 Requests arriving while busy=1 SHALL be ignored until IDLE, and SHALL NOT be lost if still held.
REQ-028 A req dropped before its gnt SHALL yield no grant and no operation.
REQ-029 gnt0 and gnt1 SHALL never be high together, and done SHALL fire exactly once per grant.
REQ-030 The ORed operand bit patterns 0x00000000 and 0xFFFFFFFF SHALL pass unmodified (no width truncation of core_xin).

Reset
REQ-031 reset=0 at a posedge SHALL force, in any state and at any point mid-operation:
  - state=IDLE, counter=0, RR pointer=favour req0;
  - gnt0=gnt1=done=done_id=busy=0;
  - core_start=core_stop=0;
  - core_xin=0, result=0.
REQ-032 An operation aborted by reset SHALL produce no done after reset releases.

Verification
REQ-033 Single op: req0=1 with x0=144, held until gnt0 -> gnt0 at k+1; core_start at k+1; core_stop at k+18; done=1, done_id=0, result=12 at k+20.
REQ-034 Tie: req0 and req1 both held from reset release, x0=0x00010000, x1=0xFFFFFFFF -> grants in order 0,1 with no idle cycle between ops; results 256 then 65535; done pulses 20 cycles apart.
REQ-035 Fairness: req0 held continuously, req1 asserted during op 1 -> next grant goes to req1; the grant after that goes to req0.
REQ-036 Reset mid-RUN: reset=0 for 2 cycles at RUN cycle 8 -> all outputs 0 on the next edge; no done after release; a fresh req1, x1=2 -> result=1.
REQ-037 Sweep: for x = 0, 2^i and 2^i+i (i=0..31) through alternating requesters -> every result matches the bitwise reference sqrt model; gnt count = done count.

Source files
------------

// File: rtl/psdsqrt_sched_if.sv
// Request/grant, completion and sqrt-core handshake bundle for psdsqrt_sched.
// Latency: none, wires only.
// Backpressure: requesters hold req high until their gnt pulse; the core is strobed by start/stop.
interface psdsqrt_sched_if;
  logic        req0;
  logic [31:0] x0;
  logic        req1;
  logic [31:0] x1;
  logic        gnt0;
  logic        gnt1;
  logic        busy;
  logic        done;
  logic        done_id;
  logic [15:0] result;
  logic        core_start;
  logic        core_stop;
  logic [31:0] core_xin;
  logic [15:0] core_sqrt;

  // Requesters and the sqrt core sit on the master side.
  modport master (
    output req0, x0, req1, x1, core_sqrt,
    input  gnt0, gnt1, busy, done, done_id, result, core_start, core_stop, core_xin
  );

  // The scheduler sits on the slave side.
  modport slave (
    input  req0, x0, req1, x1, core_sqrt,
    output gnt0, gnt1, busy, done, done_id, result, core_start, core_stop, core_xin
  );
endinterface

// File: rtl/psdsqrt_sched.sv
// Round-robin scheduler sharing one multi-cycle sqrt core between two requesters.
// Latency: request-sample edge to done pulse is ITER+4 cycles; one operation in flight.
// Backpressure: requests are only sampled in IDLE; held requests wait, dropped ones vanish.
module psdsqrt_sched #(
  parameter int ITER = 16
) (
  input  logic           clock_i,
  input  logic           reset_i,
  psdsqrt_sched_if.slave bus
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {IDLE, START, RUN, STOP, CAPTURE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          rr_q;      // requester favoured on a tie (0 = req0)
  logic          tag_q;     // requester owning the operation in flight
  logic          gnt0_q;
  logic          gnt1_q;
  logic          busy_q;
  logic          done_q;
  logic          done_id_q;
  logic [15:0]   result_q;
  logic          start_q;
  logic          stop_q;
  logic [31:0]   xin_q;
  logic          win_d;

  // Pick the winner of the current request pattern: lone request wins, tie goes to rr_q.
  always_comb begin
    win_d = 1'b0;
    if (bus.req0 && bus.req1) begin
      win_d = rr_q;
    end else if (bus.req1) begin
      win_d = 1'b1;
    end
  end

  // Sequencer: arbitrate in IDLE, then START, RUN x ITER, STOP, CAPTURE with registered outputs.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      tag_q     <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      result_q  <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      xin_q     <= '0;
    end else begin
      // Pulse outputs default low; each state raises only what it owns.
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state_q <= START;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            tag_q   <= win_d;
            rr_q    <= ~win_d;
            xin_q   <= win_d ? bus.x1 : bus.x0;
          end else begin
            busy_q <= 1'b0;
          end
        end
        START: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
        RUN: begin
          if (cnt_q == RUN_LAST) begin
            state_q <= STOP;
            stop_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          // Core output register loads on this edge; it is readable during CAPTURE.
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          done_id_q <= tag_q;
          result_q  <= bus.core_sqrt;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.done_id    = done_id_q;
  assign bus.result     = result_q;
  assign bus.core_start = start_q;
  assign bus.core_stop  = stop_q;
  assign bus.core_xin   = xin_q;

endmodule

// File: tb/tb_psdsqrt_sched.sv
// Bench for psdsqrt_sched: requester queues, a behavioural sqrt core and scenario tasks.
// Latency: expectations are derived from queued operands and round-robin rules.
// Backpressure: requests stay high until their grant pulse is observed.
module tb_psdsqrt_sched;
  localparam int ITER = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  psdsqrt_sched_if bus();
  psdsqrt_sched #(.ITER(ITER)) dut (.clock_i(clock), .reset_i(reset), .bus(bus));

  typedef struct { bit id; int cyc; bit both; bit pr0; bit pr1; } grec_t;
  typedef struct { bit id; logic [15:0] res; int cyc; bit stable; } drec_t;
  typedef struct { bit id; logic [15:0] res; } erec_t;
  typedef struct { int cyc; int span; bit stable; } srec_t;

  logic [31:0] p0[$];
  logic [31:0] p1[$];
  grec_t gq[$];
  drec_t dq[$];
  erec_t eq[$];
  srec_t sq[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int missed = 0;
  int st_cyc = 0;
  logic [31:0] st_x = '0;
  bit extra1 = 1'b0;
  bit want = 1'b0;

  // Reference square root: build the root one bit at a time, keeping a bit when r*r <= x.
  function automatic logic [15:0] isqrt(input logic [31:0] x);
    longint unsigned r;
    longint unsigned c;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      c = r + (64'd1 << b);
      if (c * c <= {32'd0, x}) r = c;
    end
    return r[15:0];
  endfunction

  // Behavioural sqrt core: the stop strobe loads its output register.
  always @(posedge clock) if (bus.core_stop === 1'b1) bus.core_sqrt <= isqrt(bus.core_xin);

  task automatic drive_reqs();
    bus.req0 = (p0.size() > 0);
    bus.x0   = (p0.size() > 0) ? p0[0] : $urandom;
    bus.req1 = (p1.size() > 0) || extra1;
    bus.x1   = (p1.size() > 0) ? p1[0] : $urandom;
    want     = reset && (bus.busy === 1'b0) && (bus.req0 || bus.req1);
  endtask

  task automatic step();
    grec_t g;
    drec_t d;
    srec_t s;
    @(negedge clock);
    cyc++;
    if (want && !(bus.gnt0 || bus.gnt1)) missed++;
    if (bus.gnt0 || bus.gnt1) begin
      g.id = bus.gnt1; g.cyc = cyc; g.both = bus.gnt0 && bus.gnt1;
      g.pr0 = bus.req0; g.pr1 = bus.req1;
      gq.push_back(g);
      if (bus.gnt1 && p1.size() > 0) begin
        eq.push_back('{1'b1, isqrt(p1[0])});
        void'(p1.pop_front());
      end else if (!bus.gnt1 && p0.size() > 0) begin
        eq.push_back('{1'b0, isqrt(p0[0])});
        void'(p0.pop_front());
      end
    end
    if (bus.core_start) begin st_cyc = cyc; st_x = bus.core_xin; end
    if (bus.core_stop) begin
      s.cyc = cyc; s.span = cyc - st_cyc; s.stable = (bus.core_xin === st_x);
      sq.push_back(s);
    end
    if (bus.done) begin
      d.id = bus.done_id; d.res = bus.result; d.cyc = cyc; d.stable = (bus.core_xin === st_x);
      dq.push_back(d);
    end
    drive_reqs();
  endtask

  task automatic clear_logs();
    gq.delete(); dq.delete(); eq.delete(); sq.delete(); missed = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; drive_reqs();
    repeat (n) step();
    reset = 1'b1; drive_reqs();
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k = 0;
    while (dq.size() < n && k < budget) begin step(); k++; end
  endtask

  task automatic test_reset();
    p0.delete(); p1.delete(); extra1 = 1'b1;
    reset = 1'b0; drive_reqs();
    step(); step(); step();
    total++; if (bus.gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt0 got=%b exp=0", bus.gnt0); end
    total++; if (bus.gnt1 !== 1'b0) begin bad++; $display("FAIL reset_gnt1 got=%b exp=0", bus.gnt1); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.done_id !== 1'b0) begin bad++; $display("FAIL reset_done_id got=%b exp=0", bus.done_id); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.core_start !== 1'b0) begin bad++; $display("FAIL reset_core_start got=%b exp=0", bus.core_start); end
    total++; if (bus.core_stop !== 1'b0) begin bad++; $display("FAIL reset_core_stop got=%b exp=0", bus.core_stop); end
    total++; if (bus.core_xin !== 32'd0) begin bad++; $display("FAIL reset_core_xin got=%h exp=0", bus.core_xin); end
    total++; if (bus.result !== 16'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    total++; if (gq.size() != 0) begin bad++; $display("FAIL reset_no_grant got=%0d exp=0", gq.size()); end
    extra1 = 1'b0; drive_reqs();
  endtask

  task automatic test_single();
    int s;
    p0.delete(); p1.delete(); extra1 = 1'b0;
    do_reset(2); clear_logs(); step(); step();
    s = cyc; p0.push_back(32'd144); drive_reqs();
    wait_dones(1, 40);
    total++; if (dq.size() != 1 || gq.size() != 1 || sq.size() != 1) begin
      bad++; $display("FAIL single_counts got=%0d/%0d/%0d exp=1/1/1", dq.size(), gq.size(), sq.size());
    end else begin
      total++; if (gq[0].id !== 1'b0 || gq[0].cyc != s + 1) begin bad++; $display("FAIL single_gnt got=id%0d@%0d exp=id0@%0d", gq[0].id, gq[0].cyc, s + 1); end
      total++; if (sq[0].cyc != s + 18) begin bad++; $display("FAIL single_stop_cyc got=%0d exp=%0d", sq[0].cyc, s + 18); end
      total++; if (dq[0].cyc != s + ITER + 4) begin bad++; $display("FAIL single_done_cyc got=%0d exp=%0d", dq[0].cyc, s + ITER + 4); end
      total++; if (dq[0].id !== 1'b0 || dq[0].res !== 16'd12) begin bad++; $display("FAIL single_result got=id%0d,%0d exp=id0,12", dq[0].id, dq[0].res); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_at_done got=%b exp=0", bus.busy); end
    end
    step();
    total++; if (bus.done !== 1'b0 || bus.result !== 16'd12) begin bad++; $display("FAIL single_hold got=done%b,%0d exp=done0,12", bus.done, bus.result); end
  endtask

  task automatic test_tie();
    int s;
    p0.delete(); p1.delete(); extra1 = 1'b0; clear_logs();
    p0.push_back(32'h0001_0000); p1.push_back(32'hFFFF_FFFF);
    do_reset(2); s = cyc;
    wait_dones(2, 80);
    total++; if (dq.size() != 2 || gq.size() != 2) begin
      bad++; $display("FAIL tie_counts got=%0d/%0d exp=2/2", dq.size(), gq.size());
    end else begin
      total++; if (gq[0].id !== 1'b0 || gq[1].id !== 1'b1) begin bad++; $display("FAIL tie_order got=%0d,%0d exp=0,1", gq[0].id, gq[1].id); end
      total++; if (gq[0].cyc != s + 1 || gq[1].cyc != s + 1 + ITER + 4) begin bad++; $display("FAIL tie_gnt_cyc got=%0d,%0d exp=%0d,%0d", gq[0].cyc, gq[1].cyc, s + 1, s + 1 + ITER + 4); end
      total++; if (dq[0].res !== 16'd256 || dq[1].res !== 16'd65535) begin bad++; $display("FAIL tie_results got=%0d,%0d exp=256,65535", dq[0].res, dq[1].res); end
      total++; if (dq[1].cyc - dq[0].cyc != ITER + 4 || dq[0].id !== 1'b0 || dq[1].id !== 1'b1) begin bad++; $display("FAIL tie_done got=gap%0d ids%0d,%0d exp=gap%0d ids0,1", dq[1].cyc - dq[0].cyc, dq[0].id, dq[1].id, ITER + 4); end
    end
  endtask

  task automatic test_fairness();
    int k = 0;
    p0.delete(); p1.delete(); extra1 = 1'b0;
    do_reset(2); clear_logs();
    repeat (3) p0.push_back($urandom);
    drive_reqs();
    while (gq.size() < 1 && k < 30) begin step(); k++; end
    repeat (3) step();
    p1.push_back($urandom); drive_reqs();
    wait_dones(4, 150);
    total++; if (gq.size() != 4 || dq.size() != 4) begin
      bad++; $display("FAIL fair_counts got=%0d/%0d exp=4/4", gq.size(), dq.size());
    end else begin
      total++; if (gq[0].id !== 1'b0 || gq[1].id !== 1'b1 || gq[2].id !== 1'b0) begin bad++; $display("FAIL fair_order got=%0d,%0d,%0d exp=0,1,0", gq[0].id, gq[1].id, gq[2].id); end
      for (int i = 0; i < 4; i++) begin
        total++; if (dq[i].id !== eq[i].id || dq[i].res !== eq[i].res) begin bad++; $display("FAIL fair_result%0d got=id%0d,%0d exp=id%0d,%0d", i, dq[i].id, dq[i].res, eq[i].id, eq[i].res); end
      end
    end
  endtask

  task automatic test_drop();
    p0.delete(); p1.delete(); extra1 = 1'b0;
    do_reset(2); clear_logs();
    p0.push_back($urandom); drive_reqs();
    repeat (5) step();
    extra1 = 1'b1; drive_reqs();
    repeat (3) step();
    extra1 = 1'b0; drive_reqs();
    wait_dones(1, 40);
    repeat (30) step();
    total++; if (gq.size() != 1 || dq.size() != 1) begin bad++; $display("FAIL drop_counts got=%0d/%0d exp=1/1", gq.size(), dq.size()); end
    total++; if (missed != 0) begin bad++; $display("FAIL drop_missed got=%0d exp=0", missed); end
  endtask

  task automatic test_reset_mid_run();
    int s;
    p0.delete(); p1.delete(); extra1 = 1'b0;
    do_reset(2); clear_logs();
    s = cyc; p0.push_back($urandom); drive_reqs();
    while (cyc < s + 9) step();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy got=%b exp=1", bus.busy); end
    reset = 1'b0; drive_reqs();
    step();
    total++; if ({bus.gnt0, bus.gnt1, bus.done, bus.done_id, bus.busy, bus.core_start, bus.core_stop, bus.core_xin, bus.result} !== 55'd0) begin
      bad++; $display("FAIL midrst_outputs got=busy%b xin%h res%h exp=all0", bus.busy, bus.core_xin, bus.result);
    end
    step();
    reset = 1'b1; drive_reqs(); clear_logs();
    repeat (30) step();
    total++; if (dq.size() != 0 || gq.size() != 0 || sq.size() != 0) begin bad++; $display("FAIL midrst_quiet got=%0d/%0d/%0d exp=0/0/0", dq.size(), gq.size(), sq.size()); end
    p1.push_back(32'd2); drive_reqs();
    wait_dones(1, 40);
    total++; if (dq.size() != 1) begin
      bad++; $display("FAIL midrst_fresh_count got=%0d exp=1", dq.size());
    end else begin
      total++; if (dq[0].id !== 1'b1 || dq[0].res !== 16'd1) begin bad++; $display("FAIL midrst_fresh got=id%0d,%0d exp=id1,1", dq[0].id, dq[0].res); end
    end
  endtask

  task automatic run_stream(input logic [31:0] xs[$], input bit who[$], input int unsigned maxgap, input string tag);
    int n;
    bit fav;
    bit exp_id;
    n = xs.size();
    p0.delete(); p1.delete(); extra1 = 1'b0;
    do_reset(2); clear_logs();
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(maxgap, 0)) step();
      if (who[j]) p1.push_back(xs[j]); else p0.push_back(xs[j]);
      drive_reqs();
    end
    wait_dones(n, n * (ITER + 4) + 100);
    repeat (5) step();
    total++; if (dq.size() != n || gq.size() != n) begin bad++; $display("FAIL %s_counts got=%0d/%0d exp=%0d", tag, dq.size(), gq.size(), n); end
    total++; if (missed != 0) begin bad++; $display("FAIL %s_missed got=%0d exp=0", tag, missed); end
    fav = 1'b0;
    foreach (gq[i]) begin
      exp_id = (gq[i].pr0 && gq[i].pr1) ? fav : gq[i].pr1;
      total++; if (gq[i].id !== exp_id || gq[i].both) begin bad++; $display("FAIL %s_grant%0d got=%0d both%0d exp=%0d", tag, i, gq[i].id, gq[i].both, exp_id); end
      if (i > 0) begin
        total++; if (gq[i].cyc - gq[i-1].cyc < ITER + 4) begin bad++; $display("FAIL %s_spacing%0d got=%0d exp>=%0d", tag, i, gq[i].cyc - gq[i-1].cyc, ITER + 4); end
      end
      fav = ~exp_id;
    end
    for (int i = 0; i < dq.size() && i < eq.size(); i++) begin
      total++; if (dq[i].id !== eq[i].id || dq[i].res !== eq[i].res) begin bad++; $display("FAIL %s_result%0d got=id%0d,%0d exp=id%0d,%0d", tag, i, dq[i].id, dq[i].res, eq[i].id, eq[i].res); end
    end
    for (int i = 0; i < dq.size() && i < gq.size(); i++) begin
      total++; if (dq[i].cyc - gq[i].cyc != ITER + 3 || !dq[i].stable) begin bad++; $display("FAIL %s_latency%0d got=%0d stable%0d exp=%0d", tag, i, dq[i].cyc - gq[i].cyc, dq[i].stable, ITER + 3); end
    end
    foreach (sq[i]) begin
      total++; if (sq[i].span != ITER + 1 || !sq[i].stable) begin bad++; $display("FAIL %s_core%0d got=span%0d stable%0d exp=span%0d", tag, i, sq[i].span, sq[i].stable, ITER + 1); end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] xs[$];
    bit who[$];
    xs.push_back(32'd0);
    for (int i = 0; i < 32; i++) begin
      xs.push_back(32'd1 << i);
      xs.push_back((32'd1 << i) + 32'(i));
    end
    foreach (xs[j]) who.push_back(bit'(j % 2));
    run_stream(xs, who, 25, "sweep");
  endtask

  task automatic test_random();
    logic [31:0] xs[$];
    bit who[$];
    for (int j = 0; j < 24; j++) begin
      case ($urandom_range(3, 0))
        0: xs.push_back(32'hFFFF_FFFF);
        1: xs.push_back($urandom_range(1000, 0));
        default: xs.push_back($urandom);
      endcase
      who.push_back(bit'($urandom_range(1, 0)));
    end
    run_stream(xs, who, 30, "random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_drop();
    test_reset_mid_run();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
